// File: rtl/inst_fetch_ctrl_pkg.sv
// ============================================================================
// Package : fetch_pkg
// Shared widths, default reset pc and FSM state encoding for the fetch stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int XLEN   = 64;
   localparam int INST_W = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/inst_fetch_ctrl_if.sv
// ============================================================================
// Interface : inst_fetch_ctrl_if
// Redirect, fetch-memory and IF/ID handshake signals of the fetch controller.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface inst_fetch_ctrl_if;
   import fetch_pkg::*;

   logic                redirect_valid;
   logic [XLEN-1:0]     redirect_pc;
   logic [XLEN-1:0]     inst_address;
   logic                ce;
   logic [INST_W-1:0]   inst;
   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     out_pc;
   logic [INST_W-1:0]   out_inst;
   logic                misalign;

   modport master (
      input  redirect_valid, redirect_pc, inst, out_ready,
      output inst_address, ce, out_valid, out_pc, out_inst, misalign
   );

   modport slave (
      output redirect_valid, redirect_pc, inst, out_ready,
      input  inst_address, ce, out_valid, out_pc, out_inst, misalign
   );

endinterface : inst_fetch_ctrl_if

`default_nettype wire

// File: rtl/inst_fetch_ctrl_pc_reg.sv
// ============================================================================
// Module : pc_reg
// Program counter register; loads next_pc when load is set, else holds.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_reg
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] r_pc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (load) begin
         r_pc <= next_pc;
      end
   end

   assign pc = r_pc;

endmodule : pc_reg

`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
// ============================================================================
// Module : inst_fetch_ctrl
// Fetch FSM, pc sequencing and IF/ID holding register with backpressure.
// Option : FETCH_MISALIGN_TRAP_EN -- halt on misaligned redirect target.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clock,
   input  logic               reset,
   inst_fetch_ctrl_if.master  bus
);

   fetch_state_t        r_state;
   fetch_state_t        w_next_state;
   logic                w_capture;
   logic [XLEN-1:0]     w_pc;
   logic [XLEN-1:0]     w_next_pc;
   logic [XLEN-1:0]     w_redirect_pc;
   logic                w_pc_load;
   logic                r_out_valid;
   logic [XLEN-1:0]     r_out_pc;
   logic [INST_W-1:0]   r_out_inst;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic w_misaligned;
   logic r_misalign;

   assign w_misaligned  = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
   assign w_redirect_pc = bus.redirect_pc;
`else
   // Low bits are dropped so every fetch address stays word aligned.
   assign w_redirect_pc = bus.redirect_pc & ~XLEN'(3);
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      case (r_state)
         ST_BOOT:  w_next_state = ST_FETCH;
         ST_FETCH: w_capture = !bus.redirect_valid && (!r_out_valid || bus.out_ready);
         ST_HALT:  if (bus.redirect_valid) w_next_state = ST_FETCH;
         default:  w_next_state = ST_BOOT;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_misaligned) begin
         w_next_state = ST_HALT;
      end
`endif
   end

   assign w_pc_load = bus.redirect_valid || w_capture;
   assign w_next_pc = bus.redirect_valid ? w_redirect_pc : (w_pc + XLEN'(4));

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clock   (clock),
      .reset   (reset),
      .load    (w_pc_load),
      .next_pc (w_next_pc),
      .pc      (w_pc)
   );

   // A redirect squashes whatever is held, even under backpressure.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_pc    <= '0;
         r_out_inst  <= '0;
      end else if (bus.redirect_valid) begin
         r_out_valid <= 1'b0;
      end else if (w_capture) begin
         r_out_valid <= 1'b1;
         r_out_pc    <= w_pc;
         r_out_inst  <= bus.inst;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else if (bus.redirect_valid) begin
         r_misalign <= w_misaligned;
      end
   end

   assign bus.misalign = r_misalign;
`else
   assign bus.misalign = 1'b0;
`endif

   assign bus.ce           = w_capture;
   assign bus.inst_address = w_pc;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_pc       = r_out_pc;
   assign bus.out_inst     = r_out_inst;

endmodule : inst_fetch_ctrl

`default_nettype wire
